// File: rtl/cru_chain.sv
// cru_chain: N cascaded clock-enable dividers off one clock, with ordered reset release, soft reset,
// and ratio reprogramming applied only at a wrap. Define CRU_PULSE_CNT_EN to add the en_cnt pulse counters.
module cru_chain #(
  parameter int                 N           = 3,
  parameter int                 DIV_W       = 16,
  parameter logic [N*DIV_W-1:0] DIV_INIT    = {16'd30, 16'd250, 16'd1},
  parameter int                 SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N-1:0]                         soft_rst_req,
  input  logic                                 div_wr,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] div_sel,
  input  logic [DIV_W-1:0]                     div_val,
  output logic [N-1:0]                         div_pending,
  output logic [N-1:0]                         en_o,
  output logic [N-1:0]                         rst_o,
  output logic                                 ready
`ifdef CRU_PULSE_CNT_EN
  ,
  output logic [N*16-1:0]                      en_cnt
`endif
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [SYNC_STAGES-1:0] r_base_sync;
  logic                   w_rst_base;
  logic [DIV_W-1:0]       r_cnt    [N];
  logic [DIV_W-1:0]       r_div    [N];
  logic [DIV_W-1:0]       r_shadow [N];
  logic [SYNC_STAGES-1:0] r_rst_sr [N];
  logic [N-1:0]           r_pending;
  logic                   r_ready;
  logic [N-1:0]           w_parent_rst;
  logic [N-1:0]           w_en_in;
  logic [N-1:0]           w_rst_set;
  logic [DIV_W-1:0]       w_div_new;

  assign w_rst_base  = r_base_sync[SYNC_STAGES-1];
  assign w_div_new   = (div_val == '0) ? DIV_W'(1) : div_val;
  assign div_pending = r_pending;
  assign ready       = r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_base_sync <= '1;
    else       r_base_sync <= {r_base_sync[SYNC_STAGES-2:0], 1'b0};
  end

  always_comb begin
    rst_o = '0;
    for (int k = 0; k < N; k++) rst_o[k] = r_rst_sr[k][SYNC_STAGES-1];
  end

  // Parent reset and enable ripple down the chain, so a child pulse always nests inside its parent's.
  always_comb begin
    logic w_par;
    logic w_en_prev;
    logic w_soft;
    w_parent_rst = '0;
    w_en_in      = '0;
    w_rst_set    = '0;
    en_o         = '0;
    w_par        = w_rst_base;
    w_en_prev    = 1'b1;
    w_soft       = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_soft          = w_soft | soft_rst_req[k];
      w_parent_rst[k] = w_par;
      w_en_in[k]      = w_en_prev & ~w_par;
      en_o[k]         = w_en_in[k] & (r_cnt[k] == (r_div[k] - DIV_W'(1)));
      w_rst_set[k]    = w_par | w_soft;
      w_par           = rst_o[k];
      w_en_prev       = en_o[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        r_cnt[k]    <= '0;
        r_div[k]    <= DIV_INIT[k*DIV_W +: DIV_W];
        r_shadow[k] <= DIV_INIT[k*DIV_W +: DIV_W];
        r_rst_sr[k] <= '1;
      end
      r_pending <= '0;
      r_ready   <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_parent_rst[k])  r_cnt[k] <= '0;
        else if (w_en_in[k])  r_cnt[k] <= en_o[k] ? '0 : r_cnt[k] + DIV_W'(1);

        if (w_rst_set[k])     r_rst_sr[k] <= '1;
        else if (en_o[k])     r_rst_sr[k] <= {r_rst_sr[k][SYNC_STAGES-2:0], 1'b0};

        // A new ratio lands only at a wrap (or while the counter is held), so no period is cut short.
        if (r_pending[k] && (en_o[k] || w_parent_rst[k])) begin
          r_div[k]     <= r_shadow[k];
          r_pending[k] <= 1'b0;
        end
        if (div_wr && (div_sel == SEL_W'(k))) begin
          r_shadow[k]  <= w_div_new;
          r_pending[k] <= 1'b1;
        end
      end
      r_ready <= ~|rst_o;
    end
  end

`ifdef CRU_PULSE_CNT_EN
  logic [15:0] r_pcnt [N];

  // Cleared on the same edge that asserts rst_o, so the count reads zero for the whole reset window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) r_pcnt[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_rst_set[k] || rst_o[k]) r_pcnt[k] <= '0;
        else if (en_o[k])             r_pcnt[k] <= r_pcnt[k] + 16'd1;
      end
    end
  end

  always_comb begin
    en_cnt = '0;
    for (int k = 0; k < N; k++) en_cnt[k*16 +: 16] = r_pcnt[k];
  end
`endif

endmodule

// File: tb/tb_cru_chain.sv
// Bench for cru_chain with N=3, DIV_INIT={3,4,1}: reset release order, rates, runtime ratio,
// soft reset, zero ratio, ignored select and asynchronous reset.
`timescale 1ns/1ps
module tb_cru_chain;
  localparam int                 N        = 3;
  localparam int                 DIV_W    = 16;
  localparam logic [N*DIV_W-1:0] DIV_INIT = {16'd3, 16'd4, 16'd1};

  logic             clk          = 1'b0;
  logic             reset        = 1'b1;
  logic [N-1:0]     soft_rst_req = '0;
  logic             div_wr       = 1'b0;
  logic [1:0]       div_sel      = '0;
  logic [DIV_W-1:0] div_val      = '0;
  logic [N-1:0]     div_pending;
  logic [N-1:0]     en_o;
  logic [N-1:0]     rst_o;
  logic             ready;
`ifdef CRU_PULSE_CNT_EN
  logic [N*16-1:0]  en_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_q[$];

  cru_chain #(.N(N), .DIV_W(DIV_W), .DIV_INIT(DIV_INIT), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req), .div_wr(div_wr),
    .div_sel(div_sel), .div_val(div_val), .div_pending(div_pending),
    .en_o(en_o), .rst_o(rst_o), .ready(ready)
`ifdef CRU_PULSE_CNT_EN
    , .en_cnt(en_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Steps to the next negedge where en_o[k] is high; at = cycle number or -1 on timeout.
  task automatic wait_en(input int k, output int at);
    at = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (en_o[k]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_en%0d: no pulse within 100 clk", k);
    end
  endtask

  task automatic test_reset();
    int e;
    repeat (3) @(negedge clk);
    exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    e = exp_q.pop_front(); checks++;
    if (int'(rst_o) !== e) begin errors++; $display("FAIL reset_rst_o: got %0d expected %0d", rst_o, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(en_o) !== e) begin errors++; $display("FAIL reset_en_o: got %0d expected %0d", en_o, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL reset_pending: got %0d expected %0d", div_pending, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(ready) !== e) begin errors++; $display("FAIL reset_ready: got %0d expected %0d", ready, e); end
  endtask

  // Releases reset and checks the release timeline and the {3,4,1} rates.
  task automatic test_release();
    int k0, t_e0, t_r0, t_r1, t_r2, t_rdy, bad, a, b, e;
    t_e0 = -1; t_r0 = -1; t_r1 = -1; t_r2 = -1; t_rdy = -1; bad = 0;
    @(negedge clk);
    reset = 1'b0;
    k0 = cyc;
    exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(12);
    exp_q.push_back(36); exp_q.push_back(37); exp_q.push_back(0);
    for (int i = 0; i < 80 && t_rdy < 0; i++) begin
      @(negedge clk);
      if (en_o[0] && t_e0 < 0)  t_e0  = cyc - k0;
      if (!rst_o[0] && t_r0 < 0) t_r0  = cyc - k0;
      if (!rst_o[1] && t_r1 < 0) t_r1  = cyc - k0;
      if (!rst_o[2] && t_r2 < 0) t_r2  = cyc - k0;
      if (ready && t_rdy < 0)    t_rdy = cyc - k0;
      if ((!rst_o[1] && rst_o[0]) || (!rst_o[2] && rst_o[1])) bad++;
      if ((en_o[2] && !en_o[1]) || (en_o[1] && !en_o[0])) bad++;
`ifdef CRU_PULSE_CNT_EN
      if (rst_o[2] && en_cnt[47:32] != 16'd0) bad++;
`endif
    end
    e = exp_q.pop_front(); checks++;
    if (t_e0 !== e) begin errors++; $display("FAIL first_en0: got %0d expected %0d", t_e0, e); end
    e = exp_q.pop_front(); checks++;
    if (t_r0 !== e) begin errors++; $display("FAIL rst0_release: got %0d expected %0d", t_r0, e); end
    e = exp_q.pop_front(); checks++;
    if (t_r1 !== e) begin errors++; $display("FAIL rst1_release: got %0d expected %0d", t_r1, e); end
    e = exp_q.pop_front(); checks++;
    if (t_r2 !== e) begin errors++; $display("FAIL rst2_release: got %0d expected %0d", t_r2, e); end
    e = exp_q.pop_front(); checks++;
    if (t_rdy !== e) begin errors++; $display("FAIL ready_rise: got %0d expected %0d", t_rdy, e); end
    e = exp_q.pop_front(); checks++;
    if (bad !== e) begin errors++; $display("FAIL release_order: got %0d violations expected %0d", bad, e); end

    exp_q.push_back(4);
    wait_en(1, a); wait_en(1, b);
    e = exp_q.pop_front(); checks++;
    if (b - a !== e) begin errors++; $display("FAIL en1_period: got %0d expected %0d", b - a, e); end
    exp_q.push_back(1); exp_q.push_back(12);
    wait_en(2, a);
    e = exp_q.pop_front(); checks++;
    if (int'(en_o[1]) !== e) begin errors++; $display("FAIL en2_nested: en_o[1] got %0d expected %0d", en_o[1], e); end
    wait_en(2, b);
    e = exp_q.pop_front(); checks++;
    if (b - a !== e) begin errors++; $display("FAIL en2_period: got %0d expected %0d", b - a, e); end
  endtask

  task automatic test_pulse_cnt();
`ifdef CRU_PULSE_CNT_EN
    logic [15:0] s0, s1, s2, d0, d1, d2;
    int e;
    @(negedge clk);
    s0 = en_cnt[15:0]; s1 = en_cnt[31:16]; s2 = en_cnt[47:32];
    exp_q.push_back(120); exp_q.push_back(30); exp_q.push_back(10);
    repeat (120) @(negedge clk);
    d0 = en_cnt[15:0] - s0; d1 = en_cnt[31:16] - s1; d2 = en_cnt[47:32] - s2;
    e = exp_q.pop_front(); checks++;
    if (int'(d0) !== e) begin errors++; $display("FAIL en_cnt0: got %0d expected %0d", d0, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(d1) < e - 1 || int'(d1) > e + 1) begin errors++; $display("FAIL en_cnt1: got %0d expected %0d+-1", d1, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(d2) < e - 1 || int'(d2) > e + 1) begin errors++; $display("FAIL en_cnt2: got %0d expected %0d+-1", d2, e); end
`endif
  endtask

  task automatic test_runtime_ratio();
    int t0, t1, t2, t3, a, b, e;
    wait_en(1, t0);
    @(negedge clk);
    div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd6;
    exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(0);
    exp_q.push_back(6); exp_q.push_back(6); exp_q.push_back(18);
    @(negedge clk);
    div_wr = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL ratio_pending_set: got %0d expected %0d", div_pending, e); end
    wait_en(1, t1);
    e = exp_q.pop_front(); checks++;
    if (t1 - t0 !== e) begin errors++; $display("FAIL ratio_old_period: got %0d expected %0d", t1 - t0, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL ratio_pending_at_wrap: got %0d expected %0d", div_pending, e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL ratio_pending_clear: got %0d expected %0d", div_pending, e); end
    wait_en(1, t2);
    e = exp_q.pop_front(); checks++;
    if (t2 - t1 !== e) begin errors++; $display("FAIL ratio_new_period1: got %0d expected %0d", t2 - t1, e); end
    wait_en(1, t3);
    e = exp_q.pop_front(); checks++;
    if (t3 - t2 !== e) begin errors++; $display("FAIL ratio_new_period2: got %0d expected %0d", t3 - t2, e); end
    wait_en(2, a); wait_en(2, b);
    e = exp_q.pop_front(); checks++;
    if (b - a !== e) begin errors++; $display("FAIL ratio_en2_period: got %0d expected %0d", b - a, e); end
  endtask

  task automatic test_soft_reset();
    int a, n, bad, e;
    bad = 0;
    @(negedge clk);
    soft_rst_req = 3'b010;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rst_o !== 3'b110 || en_o[2] !== 1'b0) bad++;
    end
    soft_rst_req = '0;
    e = exp_q.pop_front(); checks++;
    if (bad !== e) begin errors++; $display("FAIL soft_hold: got %0d violations expected %0d", bad, e); end
    // A pulse in this cycle already counts: the edge that ends it sees the request low.
    n = en_o[1] ? 1 : 0;
    while (n < 2) begin
      wait_en(1, a);
      if (a < 0) break;
      n++;
    end
    e = exp_q.pop_front(); checks++;
    if (int'(rst_o[1]) !== e) begin errors++; $display("FAIL soft_rst1_held: got %0d expected %0d", rst_o[1], e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (int'(rst_o) !== e) begin errors++; $display("FAIL soft_rst1_release: rst_o got %0d expected %0d", rst_o, e); end
    wait_en(2, a); wait_en(2, a);
    e = exp_q.pop_front(); checks++;
    if (int'(rst_o[2]) !== e) begin errors++; $display("FAIL soft_rst2_held: got %0d expected %0d", rst_o[2], e); end
    e = exp_q.pop_front(); checks++;
    if (int'(ready) !== e) begin errors++; $display("FAIL soft_ready_low: got %0d expected %0d", ready, e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (int'(rst_o) !== e) begin errors++; $display("FAIL soft_rst2_release: rst_o got %0d expected %0d", rst_o, e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (int'(ready) !== e) begin errors++; $display("FAIL soft_ready_rise: got %0d expected %0d", ready, e); end
  endtask

  task automatic test_div_zero();
    int a, b, bad, n2, e;
    bad = 0; n2 = 0;
    wait_en(2, a);
    @(negedge clk);
    div_wr = 1'b1; div_sel = 2'd2; div_val = 16'd0;
    exp_q.push_back(4); exp_q.push_back(18); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(6);
    @(negedge clk);
    div_wr = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL zero_pending_set: got %0d expected %0d", div_pending, e); end
    wait_en(2, b);
    e = exp_q.pop_front(); checks++;
    if (b - a !== e) begin errors++; $display("FAIL zero_old_period: got %0d expected %0d", b - a, e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL zero_pending_clear: got %0d expected %0d", div_pending, e); end
    for (int i = 1; i < 24; i++) begin
      @(negedge clk);
      if (en_o[2] !== en_o[1]) bad++;
      if (en_o[2]) n2++;
    end
    e = exp_q.pop_front(); checks++;
    if (bad !== e) begin errors++; $display("FAIL zero_en2_eq_en1: got %0d differences expected %0d", bad, e); end
    e = exp_q.pop_front(); checks++;
    if (n2 !== e) begin errors++; $display("FAIL zero_en2_count: got %0d expected %0d", n2, e); end
    @(negedge clk);
    div_wr = 1'b1; div_sel = 2'd3; div_val = 16'd7;
    @(negedge clk);
    div_wr = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL bad_sel_pending: got %0d expected %0d", div_pending, e); end
    wait_en(1, a); wait_en(1, b);
    e = exp_q.pop_front(); checks++;
    if (b - a !== e) begin errors++; $display("FAIL bad_sel_period: got %0d expected %0d", b - a, e); end
  endtask

  task automatic test_async_reset();
    int a, e;
    wait_en(1, a);
    @(negedge clk);
    div_wr = 1'b1; div_sel = 2'd1; div_val = 16'd9;
    exp_q.push_back(2); exp_q.push_back(7); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clk);
    div_wr = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL async_pending_before: got %0d expected %0d", div_pending, e); end
    #2 reset = 1'b1;
    #1;
    e = exp_q.pop_front(); checks++;
    if (int'(rst_o) !== e) begin errors++; $display("FAIL async_rst_o: got %0d expected %0d", rst_o, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(en_o) !== e) begin errors++; $display("FAIL async_en_o: got %0d expected %0d", en_o, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(div_pending) !== e) begin errors++; $display("FAIL async_pending: got %0d expected %0d", div_pending, e); end
    e = exp_q.pop_front(); checks++;
    if (int'(ready) !== e) begin errors++; $display("FAIL async_ready: got %0d expected %0d", ready, e); end
    repeat (3) @(negedge clk);
    test_release();
  endtask

  initial begin
    test_reset();
    test_release();
    test_pulse_cnt();
    test_runtime_ratio();
    test_soft_reset();
    test_div_zero();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cru_chain.md
Name: cru_chain

Overview:
- Parametrised clock-enable and reset unit for N cascaded clock-enable domains, all derived from one master clock.
- Domain k runs at f_clk / (DIV[0]*...*DIV[k]).
- Generates per-domain one-cycle enables, ordered per-domain reset release, per-domain soft reset, and glitch-free runtime reprogramming of each divide ratio.
- Replaces fixed-ratio, fixed-count enable/reset generation at the top of the signal chain (RF, base-band, audio, ...).

Parameters:
N, 3, number of cascaded enable domains (1..8)
DIV_W, 16, width of each divide ratio
DIV_INIT, {16'd30,16'd250,16'd1}, packed N*DIV_W reset-time ratios; slice k = DIV[k]
SYNC_STAGES, 2, reset synchronizer depth (>=2)

Ports:
clk  in  1  master clock
reset  in  1  power-on reset, asynchronous, active-high
soft_rst_req  in  N  level soft reset request per domain
div_wr  in  1  write strobe for new ratio
div_sel  in  $clog2(N) (min 1)  domain selected by div_wr
div_val  in  DIV_W  new ratio
div_pending  out  N  new ratio accepted, not yet applied
en_o  out  N  clock enable per domain, one clk cycle wide
rst_o  out  N  active-high reset per domain
ready  out  1  all domains out of reset

Behaviour:
Base reset
- reset asserts an internal rst_base and all rst_o asynchronously.
- rst_base releases through SYNC_STAGES flops clocked every clk.

Divider chain
- Per domain: counter cnt[k] (DIV_W bits) and active ratio div[k].
- en_in[0] = 1; en_in[k] = en_o[k-1].
- en_o[k] = en_in[k] && (cnt[k] == div[k]-1). It is combinational from registered state, so en_o[k] is only ever high in a cycle where en_o[k-1] is high (nested, coincident pulses).
- On en_in[k]: cnt wraps to 0 at div[k]-1, otherwise increments.
- div[k] == 1 gives en_o[k] = en_in[k].
- cnt[k] is held at 0 while its parent reset is asserted: rst_base for k=0, rst_o[k-1] for k>0.

Reset sequencing
- rst_o[k] comes from a SYNC_STAGES shift register.
- It is cleared (rst_o=1) asynchronously by reset.
- It is cleared synchronously while the parent reset is asserted or while soft_rst_req[j] is high for any j<=k.
- Otherwise it shifts in 0 only on en_o[k].
- Result: rst_o[k] deasserts in the clk cycle after the SYNC_STAGES-th en_o[k] pulse following parent release.
- Release is strictly ordered 0,1,...,N-1.

Soft reset
- soft_rst_req[k] high asserts rst_o[k..N-1] at the next clk edge.
- Counters k+1..N-1 are held at 0.
- cnt[k] keeps running, so en_o[k] keeps pulsing.
- On request deassertion, the release sequence restarts at domain k. Upstream domains are unaffected.

Runtime ratio
- div_wr loads shadow[div_sel] = max(div_val, 1) and sets div_pending[div_sel].
- The shadow is applied to div[k] (and pending cleared) at the next wrap of cnt[k], i.e. on the cycle en_o[k] is high, so no truncated period is produced.
- Applied while rst_o[k-1] (or rst_base) is asserted: immediately, on the next edge.
- A second div_wr before application overwrites the shadow; pending stays 1.
- div_wr with div_sel >= N is ignored.
- reset restores div = DIV_INIT and clears pending.
- div_val = 0 is treated as 1.

Outputs
- ready = ~|rst_o, registered.
- Reset values: rst_o = all 1, en_o = 0, div_pending = 0, ready = 0.

Optional Feature:
CRU_PULSE_CNT_EN
- With macro: adds output en_cnt (N*16), one free-running 16-bit counter per domain.
- Each counter increments on en_o[k] and wraps 0xFFFF -> 0.
- Each counter clears while rst_o[k] is asserted.
- Used by the bench and a debug register to check rates.
- Without macro: port and logic absent; all other behaviour identical.

Test Plan:
- Params N=3, DIV_INIT={3,4,1}, SYNC=2. Release reset.
  - rst_base drops after 2 clk.
  - rst_o[0] drops after 2 en_o[0] pulses (4 clk total).
  - rst_o[1] drops after the 2nd en_o[1] pulse.
  - rst_o[2] drops after the 2nd en_o[2] pulse.
  - ready rises 1 clk after rst_o[2] drops.
  - en_o[1] period 4 clk; en_o[2] period 12 clk, coincident with en_o[1].
- Steady state: write div_sel=1, div_val=6 mid-period.
  - div_pending[1]=1 until the next en_o[1], then clears.
  - Old period 4 completes; next en_o[1] period is 6 clk, en_o[2] period 18 clk.
  - No pulse shorter than 4 clk occurs.
- Pulse soft_rst_req[1] for 5 clk.
  - rst_o[1] and rst_o[2] assert next edge; rst_o[0] stays 0.
  - en_o[2] stops; en_o[1] continues.
  - After release: rst_o[1] drops after 2 en_o[1] pulses, then rst_o[2] after 2 en_o[2] pulses.
- Write div_val=0 to domain 2.
  - Applied ratio is 1; en_o[2] equals en_o[1] after the wrap.
  - div_sel=3 write is ignored: no pending bit set.
- Assert reset asynchronously mid-operation (between clk edges).
  - All rst_o=1 and en_o=0 immediately, without waiting for an edge.
  - div returns to {3,4,1}; pending cleared.
- With CRU_PULSE_CNT_EN: after ready, run 120 clk.
  - en_cnt[0] increments every clk.
  - en_cnt[1] increments 30 times (±1).
  - en_cnt[2] increments 10 times (±1).
  - en_cnt[2] is zero while rst_o[2] is asserted.
